// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI command/RAM controller.
package spi_pkg;

  localparam int SPI_WORD_W = 10;
  localparam int SPI_BYTE_W = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port byte storage: one synchronous write port, one combinational
// read port (the controller registers the read value).
module spi_ram_mem
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_SIZE-1:0]  waddr,
  input  logic [SPI_BYTE_W-1:0] wdata,
  input  logic [ADDR_SIZE-1:0]  raddr,
  output logic [SPI_BYTE_W-1:0] rdata
);

  // Contents are deliberately not reset.
  logic [SPI_BYTE_W-1:0] mem [MEM_DEPTH];

  // Write port: commits on the accepting edge, visible to any later command.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder downstream of the SPI slave: edge-detects rx_valid,
// decodes the 2-bit opcode, keeps write/read address pointers and returns
// read bytes on dout/tx_valid.
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_WORD_W-1:0] din,
  input  logic                  rx_valid,
  output logic [SPI_BYTE_W-1:0] dout,
  output logic                  tx_valid,
  output logic                  err
);

  logic                  rx_valid_d;
  logic                  accept;
  spi_cmd_e              cmd;
  logic [ADDR_SIZE-1:0]  payload_addr;

  logic [ADDR_SIZE-1:0]  wr_addr, wr_addr_next;
  logic [ADDR_SIZE-1:0]  rd_addr, rd_addr_next;
  logic                  wr_addr_vld, wr_addr_vld_next;
  logic                  rd_addr_vld, rd_addr_vld_next;
  logic [SPI_BYTE_W-1:0] dout_next;
  logic                  tx_valid_next;
  logic                  err_next;

  logic                  mem_we;
  logic [SPI_BYTE_W-1:0] mem_rdata;

  // A level held high executes once; only the 0->1 transition is a command.
  assign accept       = rx_valid & ~rx_valid_d;
  assign cmd          = spi_cmd_e'(din[SPI_WORD_W-1:SPI_BYTE_W]);
  assign payload_addr = din[ADDR_SIZE-1:0];

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (din[SPI_BYTE_W-1:0]),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // Opcode decode: next-state of pointers, flags and output registers.
  always_comb begin
    wr_addr_next     = wr_addr;
    rd_addr_next     = rd_addr;
    wr_addr_vld_next = wr_addr_vld;
    rd_addr_vld_next = rd_addr_vld;
    dout_next        = dout;
    tx_valid_next    = tx_valid;
    err_next         = 1'b0;
    mem_we           = 1'b0;

    if (accept) begin
      // Every accepted command except a successful read drops tx_valid.
      tx_valid_next = 1'b0;
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_next     = payload_addr;
          wr_addr_vld_next = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_addr_vld) begin
            mem_we = 1'b1;
            if (AUTO_INC) wr_addr_next = wr_addr + ADDR_SIZE'(1);
          end else begin
            err_next = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_next     = payload_addr;
          rd_addr_vld_next = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_addr_vld) begin
            dout_next     = mem_rdata;
            tx_valid_next = 1'b1;
            if (AUTO_INC) rd_addr_next = rd_addr + ADDR_SIZE'(1);
          end else begin
            err_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset clears everything except the memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_d  <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_addr_vld <= 1'b0;
      rd_addr_vld <= 1'b0;
      dout        <= '0;
      tx_valid    <= 1'b0;
      err         <= 1'b0;
    end else begin
      rx_valid_d  <= rx_valid;
      wr_addr     <= wr_addr_next;
      rd_addr     <= rd_addr_next;
      wr_addr_vld <= wr_addr_vld_next;
      rd_addr_vld <= rd_addr_vld_next;
      dout        <= dout_next;
      tx_valid    <= tx_valid_next;
      err         <= err_next;
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (AUTO_INC=0 and AUTO_INC=1) share
// stimulus; each is compared every cycle against a behavioural model.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;

  logic [1:0][7:0] dout_w;
  logic [1:0]      txv_w;
  logic [1:0]      err_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[0]), .tx_valid(txv_w[0]), .err(err_w[0])
  );

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[1]), .tx_valid(txv_w[1]), .err(err_w[1])
  );

  // Behavioural model state, one set per instance.
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  int         m_wa [2], m_ra [2];
  bit         m_wv [2], m_rv [2];
  logic [7:0] m_dout [2];
  bit         m_dk [2];
  bit         m_tx [2], m_err [2];
  bit         m_prev;

  task automatic chk(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h t=%0t", tag, inst, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wa[i] = 0; m_ra[i] = 0; m_wv[i] = 0; m_rv[i] = 0;
      m_dout[i] = 8'h00; m_dk[i] = 1; m_tx[i] = 0; m_err[i] = 0;
    end
    m_prev = 0;
  endfunction

  // One clock of the model, using the inputs present at this edge.
  function automatic void model_step(input bit rxv, input logic [9:0] word);
    bit acc;
    int op, p;
    acc = rxv && !m_prev;
    m_prev = rxv;
    op = int'(word[9:8]);
    p  = int'(word[7:0]);
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      if (acc) begin
        m_tx[i] = 0;
        if (op == 0) begin
          m_wa[i] = p % 256; m_wv[i] = 1;
        end else if (op == 1) begin
          if (m_wv[i]) begin
            m_mem[i][m_wa[i]] = p[7:0];
            m_known[i][m_wa[i]] = 1;
            if (i == 1) m_wa[i] = (m_wa[i] + 1) % 256;
          end else m_err[i] = 1;
        end else if (op == 2) begin
          m_ra[i] = p % 256; m_rv[i] = 1;
        end else begin
          if (m_rv[i]) begin
            m_dout[i] = m_mem[i][m_ra[i]];
            m_dk[i]   = m_known[i][m_ra[i]];
            m_tx[i]   = 1;
            if (i == 1) m_ra[i] = (m_ra[i] + 1) % 256;
          end else m_err[i] = 1;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rx_valid, din);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("tx_valid", i, {7'd0, txv_w[i]}, {7'd0, m_tx[i]});
      chk("err", i, {7'd0, err_w[i]}, {7'd0, m_err[i]});
      if (m_dk[i]) chk("dout", i, dout_w[i], m_dout[i]);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] p);
    @(negedge clk);
    din = {op, p};
    rx_valid = 1'b1;
    tick();
    @(negedge clk);
    rx_valid = 1'b0;
    tick();
    $display("cmd op=%0d payload=%h -> dout0=%h tx0=%0b dout1=%h tx1=%0b",
             op, p, dout_w[0], txv_w[0], dout_w[1], txv_w[1]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) m_known[i][a] = 0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_dout", i, dout_w[i], 8'h00);
      chk("rst_tx", i, {7'd0, txv_w[i]}, 8'h00);
      chk("rst_err", i, {7'd0, err_w[i]}, 8'h00);
    end
    rst = 1'b0;

    // Preload address 0, then reset: memory keeps its contents.
    cmd(2'b00, 8'h00);
    cmd(2'b01, 8'h5A);
    do_reset();

    // Data commands without an address: err pulses, nothing changes.
    cmd(2'b11, 8'h00);
    chk("noaddr_tx", 0, {7'd0, txv_w[0]}, 8'h00);
    cmd(2'b01, 8'h77);
    cmd(2'b10, 8'h00);
    cmd(2'b11, 8'h00);
    chk("preload", 0, dout_w[0], 8'h5A);
    chk("preload", 1, dout_w[1], 8'h5A);

    // Basic write then read.
    cmd(2'b00, 8'h3C);
    cmd(2'b01, 8'hA5);
    cmd(2'b10, 8'h3C);
    cmd(2'b11, 8'h00);
    chk("wr_rd", 0, dout_w[0], 8'hA5);
    chk("wr_rd_tx", 0, {7'd0, txv_w[0]}, 8'h01);

    // Level hold: one write only, even if din changes while held.
    cmd(2'b00, 8'h05);
    @(negedge clk);
    din = {2'b01, 8'h11};
    rx_valid = 1'b1;
    tick();
    @(negedge clk);
    din = {2'b01, 8'h99};
    repeat (11) tick();
    @(negedge clk);
    rx_valid = 1'b0;
    tick();
    cmd(2'b10, 8'h05);
    cmd(2'b11, 8'h00);
    chk("hold_once", 0, dout_w[0], 8'h11);
    chk("hold_once", 1, dout_w[1], 8'h11);
    cmd(2'b01, 8'h22);
    cmd(2'b11, 8'h00);
    chk("hold_rewrite", 0, dout_w[0], 8'h22);

    // tx_valid clear by a non-read command; dout holds.
    cmd(2'b10, 8'h01);
    chk("txclr_tx", 0, {7'd0, txv_w[0]}, 8'h00);
    chk("txclr_dout", 0, dout_w[0], 8'h22);

    // Auto-increment wrap.
    cmd(2'b00, 8'hFF);
    cmd(2'b01, 8'h10);
    cmd(2'b01, 8'h20);
    cmd(2'b10, 8'hFF);
    cmd(2'b11, 8'h00);
    chk("wrap_rd0", 1, dout_w[1], 8'h10);
    cmd(2'b11, 8'h00);
    chk("wrap_rd1", 1, dout_w[1], 8'h20);
    chk("wrap_tx", 1, {7'd0, txv_w[1]}, 8'h01);
    chk("wrap_noinc", 0, dout_w[0], 8'h20);

    // Asynchronous reset mid-read, with rx_valid already high on release.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_tx", i, {7'd0, txv_w[i]}, 8'h00);
      chk("arst_dout", i, dout_w[i], 8'h00);
      chk("arst_err", i, {7'd0, err_w[i]}, 8'h00);
    end
    model_reset();
    din = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_err", 0, {7'd0, err_w[0]}, 8'h01);
    @(negedge clk);
    rx_valid = 1'b0;
    tick();

    // Randomised traffic, including held levels and din changes mid-hold.
    for (int n = 0; n < 300; n++) begin
      int hold, gap;
      hold = int'($urandom_range(1, 3));
      gap  = int'($urandom_range(1, 2));
      @(negedge clk);
      din = 10'($urandom);
      rx_valid = 1'b1;
      tick();
      for (int h = 1; h < hold; h++) begin
        @(negedge clk);
        din = 10'($urandom);
        tick();
      end
      @(negedge clk);
      rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      $display("rand %0d din=%h -> dout0=%h tx0=%0b err0=%0b dout1=%h tx1=%0b",
               n, din, dout_w[0], txv_w[0], err_w[0], dout_w[1], txv_w[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command decoder and single-port storage placed directly downstream of the SPI slave. It consumes the slave's 10-bit parallel word (rx_data/rx_valid), treats bits [9:8] as an opcode, and performs address latching, memory writes and memory reads. It returns the read byte to the slave as tx_data/tx_valid for serialisation on MISO.

Parameters:
MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE
ADDR_SIZE, 8, address width; 1..8; address taken from din[ADDR_SIZE-1:0]
AUTO_INC, 0, 1 = post-increment the relevant address after each write-data or read-data command

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
din  input  10  word from the SPI slave (its rx_data); [9:8] opcode, [7:0] payload
rx_valid  input  1  word-valid level from the SPI slave; may stay high for many cycles
dout  output  8  read byte to the SPI slave (its tx_data)
tx_valid  output  1  dout valid; level, held until cleared
err  output  1  one-cycle pulse on an illegal data command

Behaviour:
- Reset values while rst=1: dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, wr_addr_vld=0, rd_addr_vld=0, rx_valid_d=0. Memory contents are not reset.
- Accept rule: a command is accepted only on the rising edge of rx_valid, i.e. rx_valid=1 and rx_valid_d=0 at a clk edge.
- Holding rx_valid high never re-executes a command.
- rx_valid_d is registered rx_valid.
- Opcodes, acting at the accepting edge:
  - 00 WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0]; wr_addr_vld <= 1.
  - 01 WR_DATA: if wr_addr_vld, mem[wr_addr] <= din[7:0]; otherwise err pulses and memory is unchanged.
  - 10 RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0]; rd_addr_vld <= 1.
  - 11 RD_DATA: if rd_addr_vld, dout <= mem[rd_addr] and tx_valid <= 1; otherwise err pulses and tx_valid stays 0.
- Latency: dout/tx_valid are valid one cycle after the accepting edge, i.e. visible immediately after that edge.
- Memory write latency is 1 cycle.
- RD_DATA issued right after WR_DATA to the same address returns the new data (write-first ordering across commands).
- tx_valid clear: any accepted command other than a successful RD_DATA clears tx_valid at its accepting edge; dout keeps its last value.
- Back-to-back RD_DATA keeps tx_valid=1 and updates dout.
- AUTO_INC=1: after a successful WR_DATA, wr_addr <= wr_addr+1; after a successful RD_DATA, rd_addr <= rd_addr+1.
- Address wrap: increment wraps MEM_DEPTH-1 -> 0 (modulo 2**ADDR_SIZE).
- AUTO_INC=0: addresses change only via the 00/10 opcodes.
- Payload bits above ADDR_SIZE are ignored for address commands.
- err is a registered one-cycle pulse, asserted the cycle after the bad command edge; it never blocks later commands.
- Reset mid-operation: all registers return to reset values immediately and asynchronously, which clears tx_valid and both vld flags.
- A rx_valid level already high when rst deasserts is treated as a rising edge, because rx_valid_d=0 out of reset. The bench must expect the command to execute.
- No internal FSM beyond the vld flags and edge detect; the controller is always ready and never back-pressures.

Decomposition:
- Package spi_pkg:
  - typedef enum logic[1:0] spi_cmd_e {CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11}
  - localparam SPI_WORD_W=10, SPI_BYTE_W=8
- Sub-module spi_ram_mem holds the storage:
  - parameterised MEM_DEPTH/ADDR_SIZE
  - one synchronous write port (we, waddr, wdata)
  - one read port (raddr, rdata); asynchronous read, registered in spi_ram_ctrl
- spi_ram_ctrl holds edge detect, opcode decode, address registers, vld flags, err and output registers.

Test Plan:
- Write/read: 00_0x3C, 01_0xA5, 10_0x3C, 11_xx -> dout=0xA5 and tx_valid=1 one cycle after the 4th rx_valid rise; err never asserts.
- Level hold: rx_valid held high 12 cycles with 01_0x11 after wr_addr=0x05 -> exactly one write. Then a separate 01_0x22 and a read of 0x05 -> dout=0x22, proving no repeated commands.
- No-address errors: after reset, 11_xx -> err one-cycle pulse, tx_valid=0. Then 01_0x77 -> err pulse, memory unchanged (a later read of address 0 returns the preloaded value).
- AUTO_INC=1 wrap: wr_addr=0xFF, write 0x10 then 0x20 -> mem[0xFF]=0x10, mem[0x00]=0x20. rd_addr=0xFF with two RD_DATA -> dout 0x10 then 0x20, tx_valid held high across both.
- tx_valid clear: after a successful read (tx_valid=1), issue 10_0x01 -> tx_valid=0 at that edge, dout unchanged.
- Reset mid-read: assert rst while tx_valid=1 -> tx_valid, dout and err go 0 without a clock edge. After release, 11_xx -> err pulse, because rd_addr_vld was cleared.
